// File: rtl/ooo_pkg.sv
// Shared out-of-order core sizing: physical register file and architectural mapping.
package ooo_pkg;

    localparam int unsigned PREG_COUNT     = 64;
    localparam int unsigned PREG_IW        = $clog2(PREG_COUNT);
    localparam int unsigned ARCH_REG_COUNT = 32;

    typedef logic [PREG_IW-1:0] preg_idx_t;

endpackage

// File: rtl/multi_pick_encoder.sv
// Combinational N-pick priority encoder: returns the PICKS lowest indices whose
// busy bit is clear, in ascending order, each with a valid flag.
module multi_pick_encoder #(
    parameter int unsigned ENTRY_COUNT = 64,
    parameter int unsigned PICKS       = 2,
    localparam int unsigned IW         = $clog2(ENTRY_COUNT)
) (
    input  logic [ENTRY_COUNT-1:0] i_busy,
    output logic [PICKS*IW-1:0]    o_pick_index,
    output logic [PICKS-1:0]       o_pick_valid
);

    always_comb begin
        int unsigned w_found;
        o_pick_index = '0;
        o_pick_valid = '0;
        w_found      = 0;
        for (int unsigned i = 0; i < ENTRY_COUNT; i++) begin
            if (!i_busy[i]) begin
                for (int unsigned p = 0; p < PICKS; p++) begin
                    if (w_found == p) begin
                        o_pick_index[p*IW +: IW] = IW'(i);
                        o_pick_valid[p]          = 1'b1;
                    end
                end
                w_found++;
            end
        end
    end

endmodule

// File: rtl/free_list_allocator.sv
// Multi-port physical-register free list: N-wide lowest-index allocation with
// all-or-nothing stall, multi-channel release. Optional FREELIST_CHECK_EN adds err_double_free.
module free_list_allocator
    import ooo_pkg::*;
#(
    parameter int unsigned ENTRY_COUNT = PREG_COUNT,
    parameter int unsigned ALLOC_WIDTH = 2,
    parameter int unsigned FREE_WIDTH  = 2,
    parameter int unsigned RESERVED    = ARCH_REG_COUNT,
    localparam int unsigned IW         = $clog2(ENTRY_COUNT),
    localparam int unsigned CW         = $clog2(ENTRY_COUNT + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ALLOC_WIDTH-1:0]    alloc_req,
    output logic [ALLOC_WIDTH-1:0]    alloc_grant,
    output logic [ALLOC_WIDTH*IW-1:0] alloc_index,
    output logic                      alloc_stall,
    input  logic [FREE_WIDTH-1:0]     free_valid,
    input  logic [FREE_WIDTH*IW-1:0]  free_index,
    output logic [CW-1:0]             free_count
`ifdef FREELIST_CHECK_EN
    ,
    output logic                      err_double_free
`endif
);

    localparam logic [ENTRY_COUNT-1:0] BUSY_AT_RESET =
        {ENTRY_COUNT{1'b1}} >> (ENTRY_COUNT - RESERVED);

    logic [ENTRY_COUNT-1:0]    r_busy;
    logic [ENTRY_COUNT-1:0]    w_busy_nxt;
    logic [CW-1:0]             r_free_count;
    logic [CW-1:0]             w_free_count_nxt;
    logic [ALLOC_WIDTH*IW-1:0] w_pick_index;
    logic [ALLOC_WIDTH-1:0]    w_pick_valid;
    logic [CW-1:0]             w_req_cnt;
    logic                      w_cover;
    logic                      w_ok;
    logic [CW-1:0]             w_rel_cnt;
    logic [CW-1:0]             w_take_cnt;
    logic [FREE_WIDTH-1:0]     w_dup;

    multi_pick_encoder #(
        .ENTRY_COUNT (ENTRY_COUNT),
        .PICKS       (ALLOC_WIDTH)
    ) u_pick (
        .i_busy       (r_busy),
        .o_pick_index (w_pick_index),
        .o_pick_valid (w_pick_valid)
    );

    // Grants are all-or-nothing: either every requesting channel gets a pick or none does.
    always_comb begin
        int unsigned w_slot;
        w_req_cnt = '0;
        for (int unsigned ch = 0; ch < ALLOC_WIDTH; ch++) begin
            w_req_cnt = w_req_cnt + CW'(alloc_req[ch]);
        end
        w_cover = 1'b1;
        for (int unsigned p = 0; p < ALLOC_WIDTH; p++) begin
            if ((CW'(p) < w_req_cnt) && !w_pick_valid[p]) begin
                w_cover = 1'b0;
            end
        end
        w_ok        = (w_req_cnt <= r_free_count) && w_cover;
        alloc_stall = (w_req_cnt != '0) && !w_ok;
        alloc_grant = '0;
        alloc_index = '0;
        w_slot      = 0;
        for (int unsigned ch = 0; ch < ALLOC_WIDTH; ch++) begin
            if (alloc_req[ch] && w_ok) begin
                alloc_grant[ch]           = 1'b1;
                alloc_index[ch*IW +: IW]  = w_pick_index[w_slot*IW +: IW];
                w_slot++;
            end
        end
    end

    // Releases are applied after grants so a forced grant/release collision leaves the entry free.
    always_comb begin
        w_busy_nxt = r_busy;
        w_rel_cnt  = '0;
        w_take_cnt = '0;
        w_dup      = '0;
        for (int unsigned ch = 0; ch < ALLOC_WIDTH; ch++) begin
            if (alloc_grant[ch]) begin
                w_busy_nxt[alloc_index[ch*IW +: IW]] = 1'b1;
            end
        end
        for (int unsigned k = 0; k < FREE_WIDTH; k++) begin
            for (int unsigned j = 0; j < FREE_WIDTH; j++) begin
                if ((j < k) && free_valid[j] &&
                    (free_index[j*IW +: IW] == free_index[k*IW +: IW])) begin
                    w_dup[k] = 1'b1;
                end
            end
            if (free_valid[k]) begin
                w_busy_nxt[free_index[k*IW +: IW]] = 1'b0;
                if (r_busy[free_index[k*IW +: IW]] && !w_dup[k]) begin
                    w_rel_cnt = w_rel_cnt + 1'b1;
                end
            end
        end
        for (int unsigned ch = 0; ch < ALLOC_WIDTH; ch++) begin
            if (alloc_grant[ch] && w_busy_nxt[alloc_index[ch*IW +: IW]]) begin
                w_take_cnt = w_take_cnt + 1'b1;
            end
        end
        w_free_count_nxt = r_free_count + w_rel_cnt - w_take_cnt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy       <= BUSY_AT_RESET;
            r_free_count <= CW'(ENTRY_COUNT - RESERVED);
        end else begin
            r_busy       <= w_busy_nxt;
            r_free_count <= w_free_count_nxt;
        end
    end

    assign free_count = r_free_count;

`ifdef FREELIST_CHECK_EN
    logic w_double_free;
    logic r_err;

    always_comb begin
        w_double_free = 1'b0;
        for (int unsigned k = 0; k < FREE_WIDTH; k++) begin
            if (free_valid[k] && (!r_busy[free_index[k*IW +: IW]] || w_dup[k])) begin
                w_double_free = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_double_free) begin
            r_err <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && w_double_free) begin
            $error("free_list_allocator: release of free or duplicated index");
        end
    end
`endif

    assign err_double_free = r_err;
`endif

endmodule

// File: tb/tb_free_list_allocator.sv
// Self-checking bench for free_list_allocator: directed scenarios plus randomized
// traffic against a busy-array reference model.
module tb_free_list_allocator;
    import ooo_pkg::*;

    localparam int EC  = PREG_COUNT;
    localparam int AW  = 2;
    localparam int FW  = 2;
    localparam int RES = 32;
    localparam int IW  = 6;
    localparam int CW  = 7;

    logic              clk = 1'b0;
    logic              reset;
    logic [AW-1:0]     alloc_req;
    logic [AW-1:0]     alloc_grant;
    logic [AW*IW-1:0]  alloc_index;
    logic              alloc_stall;
    logic [FW-1:0]     free_valid;
    logic [FW*IW-1:0]  free_index;
    logic [CW-1:0]     free_count;
`ifdef FREELIST_CHECK_EN
    logic              err_double_free;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    bit               m_busy[EC];
    logic [AW-1:0]    e_grant;
    logic [AW*IW-1:0] e_idx;
    logic             e_stall;

    free_list_allocator #(
        .ENTRY_COUNT (EC),
        .ALLOC_WIDTH (AW),
        .FREE_WIDTH  (FW),
        .RESERVED    (RES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .alloc_req   (alloc_req),
        .alloc_grant (alloc_grant),
        .alloc_index (alloc_index),
        .alloc_stall (alloc_stall),
        .free_valid  (free_valid),
        .free_index  (free_index),
        .free_count  (free_count)
`ifdef FREELIST_CHECK_EN
        ,
        .err_double_free (err_double_free)
`endif
    );

    always #5 clk = ~clk;

    function automatic int m_free();
        int c = 0;
        for (int i = 0; i < EC; i++) if (!m_busy[i]) c++;
        return c;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < EC; i++) m_busy[i] = (i < RES);
    endtask

    // Expected outputs: list every free index ascending, hand them to requesters in order.
    task automatic m_expect(input logic [AW-1:0] req);
        int cand[$];
        int n;
        int c;
        for (int i = 0; i < EC; i++) if (!m_busy[i]) cand.push_back(i);
        n = $countones(req);
        e_grant = '0;
        e_idx   = '0;
        e_stall = (n != 0) && (n > cand.size());
        c = 0;
        if (!e_stall) begin
            for (int ch = 0; ch < AW; ch++) begin
                if (req[ch]) begin
                    e_grant[ch]          = 1'b1;
                    e_idx[ch*IW +: IW]   = IW'(cand[c]);
                    c++;
                end
            end
        end
    endtask

    task automatic drive(input logic [AW-1:0] req, input logic [FW-1:0] fv,
                         input logic [FW*IW-1:0] fi);
        alloc_req  = req;
        free_valid = fv;
        free_index = fi;
        m_expect(req);
    endtask

    task automatic tick();
        for (int ch = 0; ch < AW; ch++) if (e_grant[ch]) m_busy[e_idx[ch*IW +: IW]] = 1'b1;
        for (int k = 0; k < FW; k++) if (free_valid[k]) m_busy[free_index[k*IW +: IW]] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_reset();
        drive('0, '0, '0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        m_reset();
        drive(2'b11, '0, '0);
        @(negedge clk);
        n_cmp++; if (alloc_grant !== 2'b11) begin n_bad++; $display("FAIL reset_grant: got %b expected 11", alloc_grant); end
        n_cmp++; if (alloc_index !== {6'd33, 6'd32}) begin n_bad++; $display("FAIL reset_index: got %h expected %h", alloc_index, {6'd33, 6'd32}); end
        n_cmp++; if (alloc_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b expected 0", alloc_stall); end
        n_cmp++; if (free_count !== 7'd32) begin n_bad++; $display("FAIL reset_count: got %0d expected 32", free_count); end
        reset = 1'b0;
        tick();
        drive('0, '0, '0);
        @(negedge clk);
        n_cmp++; if (free_count !== 7'd30) begin n_bad++; $display("FAIL reset_count_after_grant: got %0d expected 30", free_count); end
        tick();
    endtask

    task automatic test_single_channel();
        do_reset();
        drive(2'b10, '0, '0);
        @(negedge clk);
        n_cmp++; if (alloc_grant !== 2'b10) begin n_bad++; $display("FAIL ch1_grant: got %b expected 10", alloc_grant); end
        n_cmp++; if (alloc_index !== {6'd32, 6'd0}) begin n_bad++; $display("FAIL ch1_index: got %h expected %h", alloc_index, {6'd32, 6'd0}); end
        tick();
        drive('0, '0, '0);
        @(negedge clk);
        n_cmp++; if (free_count !== 7'd31) begin n_bad++; $display("FAIL ch1_count: got %0d expected 31", free_count); end
        tick();
    endtask

    task automatic test_exhaust();
        do_reset();
        drive(2'b01, '0, '0);
        tick();
        for (int i = 0; i < 15; i++) begin
            drive(2'b11, '0, '0);
            @(negedge clk);
            n_cmp++; if (alloc_grant !== e_grant || alloc_index !== e_idx) begin
                n_bad++; $display("FAIL fill_grant: got %b/%h expected %b/%h", alloc_grant, alloc_index, e_grant, e_idx);
            end
            tick();
        end
        drive(2'b11, '0, '0);
        @(negedge clk);
        n_cmp++; if (free_count !== 7'd1) begin n_bad++; $display("FAIL low_count: got %0d expected 1", free_count); end
        n_cmp++; if (alloc_grant !== 2'b00) begin n_bad++; $display("FAIL low_grant: got %b expected 00", alloc_grant); end
        n_cmp++; if (alloc_stall !== 1'b1) begin n_bad++; $display("FAIL low_stall: got %b expected 1", alloc_stall); end
        n_cmp++; if (alloc_index !== '0) begin n_bad++; $display("FAIL low_index: got %h expected 0", alloc_index); end
        tick();
        drive(2'b01, '0, '0);
        @(negedge clk);
        n_cmp++; if (free_count !== 7'd1) begin n_bad++; $display("FAIL stall_count_held: got %0d expected 1", free_count); end
        n_cmp++; if (alloc_grant !== 2'b01 || alloc_index !== {6'd0, 6'd63}) begin
            n_bad++; $display("FAIL last_grant: got %b/%h expected 01/%h", alloc_grant, alloc_index, {6'd0, 6'd63});
        end
        tick();
        drive(2'b10, '0, '0);
        @(negedge clk);
        n_cmp++; if (free_count !== 7'd0) begin n_bad++; $display("FAIL empty_count: got %0d expected 0", free_count); end
        n_cmp++; if (alloc_stall !== 1'b1 || alloc_grant !== 2'b00) begin
            n_bad++; $display("FAIL empty_stall: got %b/%b expected 1/00", alloc_stall, alloc_grant);
        end
        tick();
    endtask

    task automatic test_release_no_bypass();
        drive(2'b11, 2'b11, {6'd40, 6'd5});
        @(negedge clk);
        n_cmp++; if (alloc_stall !== 1'b1 || alloc_grant !== 2'b00) begin
            n_bad++; $display("FAIL bypass_stall: got %b/%b expected 1/00", alloc_stall, alloc_grant);
        end
        tick();
        drive(2'b11, '0, '0);
        @(negedge clk);
        n_cmp++; if (free_count !== 7'd2) begin n_bad++; $display("FAIL release_count: got %0d expected 2", free_count); end
        n_cmp++; if (alloc_grant !== 2'b11 || alloc_index !== {6'd40, 6'd5}) begin
            n_bad++; $display("FAIL realloc: got %b/%h expected 11/%h", alloc_grant, alloc_index, {6'd40, 6'd5});
        end
        tick();
        drive('0, '0, '0);
        @(negedge clk);
        n_cmp++; if (free_count !== 7'd0) begin n_bad++; $display("FAIL realloc_count: got %0d expected 0", free_count); end
        tick();
    endtask

    task automatic test_double_free();
        drive('0, 2'b11, {6'd10, 6'd10});
        tick();
        drive('0, 2'b01, {6'd0, 6'd50});
        @(negedge clk);
        n_cmp++; if (free_count !== 7'd1) begin n_bad++; $display("FAIL dup_count: got %0d expected 1", free_count); end
`ifdef FREELIST_CHECK_EN
        n_cmp++; if (err_double_free !== 1'b1) begin n_bad++; $display("FAIL dup_err: got %b expected 1", err_double_free); end
`endif
        tick();
        drive('0, 2'b10, {6'd50, 6'd0});
        @(negedge clk);
        n_cmp++; if (free_count !== 7'd2) begin n_bad++; $display("FAIL free50_count: got %0d expected 2", free_count); end
        tick();
        drive('0, '0, '0);
        @(negedge clk);
        n_cmp++; if (free_count !== 7'd2) begin n_bad++; $display("FAIL refree_count: got %0d expected 2", free_count); end
`ifdef FREELIST_CHECK_EN
        n_cmp++; if (err_double_free !== 1'b1) begin n_bad++; $display("FAIL sticky_err: got %b expected 1", err_double_free); end
`endif
        tick();
    endtask

    task automatic test_reset_midstream();
        drive(2'b11, 2'b01, {6'd0, 6'd7});
        #1;
        reset = 1'b1;
        m_reset();
        m_expect(2'b11);
        @(negedge clk);
        n_cmp++; if (free_count !== 7'd32) begin n_bad++; $display("FAIL mid_reset_count: got %0d expected 32", free_count); end
        n_cmp++; if (alloc_grant !== 2'b11 || alloc_index !== {6'd33, 6'd32}) begin
            n_bad++; $display("FAIL mid_reset_grant: got %b/%h expected 11/%h", alloc_grant, alloc_index, {6'd33, 6'd32});
        end
`ifdef FREELIST_CHECK_EN
        n_cmp++; if (err_double_free !== 1'b0) begin n_bad++; $display("FAIL mid_reset_err: got %b expected 0", err_double_free); end
`endif
        reset = 1'b0;
        drive('0, '0, '0);
        tick();
    endtask

    task automatic test_random();
        logic [FW*IW-1:0] fi;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < FW; k++) fi[k*IW +: IW] = IW'($urandom_range(0, EC - 1));
            drive(AW'($urandom_range(0, 3)), FW'($urandom_range(0, 3)), fi);
            @(negedge clk);
            n_cmp++; if (alloc_grant !== e_grant) begin n_bad++; $display("FAIL rnd_grant cyc %0d: got %b expected %b", cyc, alloc_grant, e_grant); end
            n_cmp++; if (alloc_index !== e_idx) begin n_bad++; $display("FAIL rnd_index cyc %0d: got %h expected %h", cyc, alloc_index, e_idx); end
            n_cmp++; if (alloc_stall !== e_stall) begin n_bad++; $display("FAIL rnd_stall cyc %0d: got %b expected %b", cyc, alloc_stall, e_stall); end
            n_cmp++; if (free_count !== CW'(m_free())) begin n_bad++; $display("FAIL rnd_count cyc %0d: got %0d expected %0d", cyc, free_count, m_free()); end
            tick();
        end
    endtask

    initial begin
        reset      = 1'b1;
        alloc_req  = '0;
        free_valid = '0;
        free_index = '0;
        test_reset();
        test_single_channel();
        test_exhaust();
        test_release_no_bypass();
        test_double_free();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
